// File: rtl/td4_prog_mem.sv
// TD4 program memory: 16x8 store loaded byte-wise, padded with BLANK_WORD, then read combinationally in RUN.
// Optional running checksum of written words when TD4_PROG_CHECKSUM_EN is defined; otherwise checksum is 8'h00.
module td4_prog_mem #(
    parameter logic [7:0] BLANK_WORD = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_end,
    output logic       ld_ready,
    input  logic [3:0] addr,
    output logic [7:0] inst,
    output logic       run,
    output logic [4:0] ld_cnt,
    output logic [7:0] checksum
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] wptr_q, wptr_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] cnt_after;
    logic [7:0] mem_q [16];
    logic       we;
    logic [7:0] wdat;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        we        = 1'b0;
        wdat      = BLANK_WORD;
        cnt_after = cnt_q + {4'd0, ld_valid};
        if (ld_start) begin
            state_d = ST_LOAD;
            wptr_d  = 4'd0;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (ld_valid) begin
                        we     = 1'b1;
                        wdat   = ld_data;
                        wptr_d = wptr_q + 4'd1;
                        cnt_d  = cnt_after;
                    end
                    // A same-cycle byte counts before deciding between RUN and FILL.
                    if (cnt_after == 5'd16) begin
                        state_d = ST_RUN;
                    end else if (ld_end) begin
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    we     = 1'b1;
                    wptr_d = wptr_q + 4'd1;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wptr_q  <= 4'd0;
            cnt_q   <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= BLANK_WORD;
            end
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            if (we) begin
                mem_q[wptr_q] <= wdat;
            end
        end
    end

`ifdef TD4_PROG_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (ld_start) begin
            csum_d = 8'h00;
        end else if (we) begin
            csum_d = csum_q + wdat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

    assign ld_ready = (state_q == ST_LOAD);
    assign run      = (state_q == ST_RUN);
    assign ld_cnt   = cnt_q;
    assign inst     = (state_q == ST_RUN) ? mem_q[addr] : BLANK_WORD;

endmodule

// File: tb/tb_td4_prog_mem.sv
// Directed bench for td4_prog_mem: per-cycle comparison against a program-level model plus literal spot checks.
module tb_td4_prog_mem;

    localparam logic [7:0] BLANK = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;
    logic       ld_end = 1'b0;
    logic       ld_ready;
    logic [3:0] addr = 4'h0;
    logic [7:0] inst;
    logic       run;
    logic [4:0] ld_cnt;
    logic [7:0] checksum;

    td4_prog_mem #(.BLANK_WORD(BLANK)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_end   (ld_end),
        .ld_ready (ld_ready),
        .addr     (addr),
        .inst     (inst),
        .run      (run),
        .ld_cnt   (ld_cnt),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-level model: phase 0 idle, 1 loading, 2 padding, 3 running.
    logic [7:0] m_mem [16];
    int         m_cnt;
    int         m_phase;
    logic [7:0] m_csum;

    task automatic m_write(input logic [7:0] d);
        m_mem[m_cnt] = d;
        m_cnt++;
        m_csum = m_csum + d;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
            m_csum  = 8'h00;
            for (int i = 0; i < 16; i++) m_mem[i] = BLANK;
        end else if (ld_start) begin
            m_phase = 1;
            m_cnt   = 0;
            m_csum  = 8'h00;
        end else if (m_phase == 1) begin
            if (ld_valid) m_write(ld_data);
            if (m_cnt == 16) m_phase = 3;
            else if (ld_end) m_phase = 2;
        end else if (m_phase == 2) begin
            m_write(BLANK);
            if (m_cnt == 16) m_phase = 3;
        end
    end

    function automatic logic [7:0] exp_csum(input logic [7:0] v);
`ifdef TD4_PROG_CHECKSUM_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("run", {31'd0, run}, {31'd0, m_phase == 3});
            chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_phase == 1});
            chk("ld_cnt", {27'd0, ld_cnt}, m_cnt);
            chk("inst", {24'd0, inst}, {24'd0, (m_phase == 3) ? m_mem[addr] : BLANK});
            chk("checksum", {24'd0, checksum}, {24'd0, exp_csum(m_csum)});
        end
    end

    task automatic step(input logic s, input logic v, input logic [7:0] d, input logic e);
        ld_start = s;
        ld_valid = v;
        ld_data  = d;
        ld_end   = e;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_end   = 1'b0;
    endtask

    task automatic wait_run(input string name, input int exp_cycles, input int limit);
        int n;
        n = 0;
        while (run !== 1'b1 && n < limit) begin
            step(1'b0, 1'b1, 8'hEE, 1'b0);
            n++;
        end
        chk(name, n, exp_cycles);
    endtask

    task automatic spot_inst(input string name, input logic [3:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(name, {24'd0, inst}, {24'd0, exp});
    endtask

    initial begin
        #2;
        cmp_en = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        spot_inst("reset_inst", 4'h3, BLANK);
        chk("reset_cnt", {27'd0, ld_cnt}, 32'd0);
        chk("reset_run", {31'd0, run}, 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h44, 1'b1);

        // Full 16-byte load.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        chk("full_run", {31'd0, run}, 32'd1);
        chk("full_cnt", {27'd0, ld_cnt}, 32'd16);
        spot_inst("full_addr5", 4'h5, 8'h05);
        chk("full_csum", {24'd0, checksum}, {24'd0, exp_csum(8'h78)});
        step(1'b0, 1'b1, 8'h99, 1'b1);
        spot_inst("run_ignores_ld", 4'hF, 8'h0F);

        // Reload from RUN with gapped valid, then pad.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("reload_run", {31'd0, run}, 32'd0);
        chk("reload_rdy", {31'd0, ld_ready}, 32'd1);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b0, 8'hBB, 1'b0);
        step(1'b0, 1'b1, 8'hCC, 1'b0);
        step(1'b0, 1'b0, 8'hDD, 1'b0);
        chk("gap_cnt", {27'd0, ld_cnt}, 32'd2);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        wait_run("gap_fill_cycles", 14, 40);
        spot_inst("reload_loc0", 4'h0, 8'hAA);
        spot_inst("reload_loc1", 4'h1, 8'hCC);
        spot_inst("reload_loc2", 4'h2, BLANK);

        // Short program with ld_end on the last byte.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h31, 1'b0);
        step(1'b0, 1'b1, 8'hB3, 1'b1);
        wait_run("short_fill_cycles", 14, 40);
        spot_inst("short_loc0", 4'h0, 8'h31);
        spot_inst("short_loc1", 4'h1, 8'hB3);
        spot_inst("short_loc2", 4'h2, BLANK);
        chk("short_csum", {24'd0, checksum}, {24'd0, exp_csum(8'hE4)});

        // Reset in the middle of a load discards it and stays idle.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", {27'd0, ld_cnt}, 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) spot_inst("rst_blank", 4'(i), BLANK);
        step(1'b0, 1'b1, 8'h12, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("idle_hold_run", {31'd0, run}, 32'd0);
        chk("idle_hold_rdy", {31'd0, ld_ready}, 32'd0);

        // Empty program: ld_end alone pads all 16 words.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        wait_run("empty_fill_cycles", 16, 40);
        for (int i = 0; i < 16; i++) spot_inst("empty_blank", 4'(i), BLANK);
        chk("empty_csum", {24'd0, checksum}, {24'd0, exp_csum(8'(16 * BLANK))});
        step(1'b0, 1'b0, 8'h00, 1'b0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
